instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the 8-bit processor: owns the program counter, issues word reads to instruction memory through a busywait handshake, and holds the fetched 32-bit word stable for the instruction splitter and control unit until the execute side releases it. It sits directly upstream of the field splitter. It also computes the next PC, either sequential or jump/branch-redirected, from a signed 8-bit word offset.

## Interface
- IMEM_AW, 8, instruction-memory word-address width; imem_addr = pc[IMEM_AW+1:2]
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-low reset
- jump  input  1  unconditional redirect for the instruction currently held
- branch_taken  input  1  conditional redirect already resolved by the ALU (zero/compare)
- offset  input  8  signed word offset (two's complement), instruction[23:16] of the held instruction
- stall  input  1  execute/data-memory busy; holds the current instruction
- imem_rdata  input  32  instruction word from memory, valid when imem_busywait low
- imem_busywait  input  1  memory not ready
- imem_read  output  1  read request
- imem_addr  output  IMEM_AW  word address
- pc  output  32  address of the held/being-fetched instruction
- instruction  output  32  registered instruction word to splitter
- instr_valid  output  1  instruction register holds a live instruction

## Operation
- FSM states: IDLE, FETCH, VALID. The reset state is IDLE.
- IDLE: outputs quiescent; unconditionally moves to FETCH on the next edge.
- FETCH:
  - imem_read=1 (decoded from state only) and imem_addr=pc[IMEM_AW+1:2].
  - On an edge with imem_busywait=0: instruction<=imem_rdata, move to VALID.
  - Otherwise remain in FETCH with pc and address stable.
- VALID:
  - instr_valid=1 and imem_read=0.
  - On an edge with stall=1: hold everything.
  - On an edge with stall=0: pc<=next_pc and move to FETCH. instruction keeps its old value; instr_valid drops.
- next_pc is computed from pc only, with 32-bit wrap-around:
  - sequential: pc+4
  - if jump|branch_taken: pc+4+(sign_extend(offset)<<2)
- jump and branch_taken asserted together give the same target as either one alone.
- jump, branch_taken and offset are sampled only on the VALID→FETCH edge and ignored in other states.
- pc stays word-aligned; bits [1:0] are always 00 given an aligned RESET_PC.

## Timing
- Reset values:
  - pc=RESET_PC
  - instruction=32'h0
  - instr_valid=0
  - imem_read=0
  - imem_addr=RESET_PC[IMEM_AW+1:2]
  - state=IDLE
- RESET assertion mid-operation clears the state immediately (asynchronously) regardless of FSM state, busywait or stall. Any pending memory read is abandoned and imem_read falls in the same instant.
- First imem_read occurs in the second cycle after RESET deasserts (IDLE→FETCH edge).
- Zero-wait memory: 2 cycles per instruction (FETCH 1 cycle, VALID 1 cycle). N wait cycles add N cycles in FETCH; M stall cycles add M cycles in VALID.
- instruction changes only on the FETCH→VALID edge, so splitter outputs are glitch-free for the whole VALID phase.
- A branch offset of -1 (8'hFF) targets the same instruction (pc+4-4), giving a legal self-loop.
- pc incrementing from 32'hFFFF_FFFC wraps to 32'h0000_0000.
- stall in FETCH is ignored; busywait in VALID is ignored.

## Test plan
- Reset/start: hold RESET=0 for 3 cycles, release with zero-wait memory returning 32'h0000_0001 at word 0 → imem_read rises on the 2nd edge. instruction=32'h0000_0001 and instr_valid=1 after the 3rd edge. pc=0. All outputs read 0 during reset.
- Sequential run: 4 words, no stall/redirect → pc sequence 0,4,8,12. instr_valid toggles 0/1 every cycle. imem_addr 0,1,2,3.
- Wait states: imem_busywait high for 3 cycles on the fetch at pc=4 → FSM stays in FETCH for 4 cycles. pc and imem_addr are stable and instruction is unchanged until busywait drops.
- Stall: stall=1 for 5 cycles in VALID at pc=8 → instruction, pc and instr_valid are held. Next fetch is at pc=12 one edge after stall falls.
- Redirect: at pc=16 apply jump=1, offset=8'h02 → next pc=28. At pc=28 apply branch_taken=1, offset=8'hFD → next pc=20. Apply offset=8'hFF → self-loop at the same pc.
- Reset mid-fetch: assert RESET during a FETCH with busywait high at pc=40 → immediately pc=0, imem_read=0, instr_valid=0. A normal restart follows release.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory through a busywait handshake
// and holds the fetched word stable until the execute side releases it.
module instruction_fetch_unit #(
  parameter int unsigned IMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               jump,
  input  logic               branch_taken,
  input  logic [7:0]         offset,
  input  logic               stall,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_busywait,
  output logic               imem_read,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        pc,
  output logic [31:0]        instruction,
  output logic               instr_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t      state, state_nx;
  logic        load_instr;
  logic        advance;
  logic [31:0] next_pc;
  logic [31:0] redirect;

  // Word offset scaled to bytes; added on top of the sequential pc+4.
  assign redirect = (jump | branch_taken) ? {{22{offset[7]}}, offset, 2'b00} : '0;
  assign next_pc  = pc + 32'd4 + redirect;

  assign imem_read   = (state == FETCH);
  assign instr_valid = (state == VALID);
  assign imem_addr   = pc[IMEM_AW+1:2];

  always_comb begin
    state_nx   = state;
    load_instr = 1'b0;
    advance    = 1'b0;
    unique case (state)
      IDLE:  state_nx = FETCH;
      FETCH: if (!imem_busywait) begin
        state_nx   = VALID;
        load_instr = 1'b1;
      end
      VALID: if (!stall) begin
        state_nx = FETCH;
        advance  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
    end else begin
      state <= state_nx;
      if (load_instr) instruction <= imem_rdata;
      if (advance)    pc          <= next_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by
// randomized instruction streams checked against a transaction-level PC model.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        jump = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  offset = '0;
  logic        stall = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_busywait = 1'b0;
  logic        imem_read;
  logic [7:0]  imem_addr;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        instr_valid;

  instruction_fetch_unit #(.IMEM_AW(8), .RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RESET(RESET), .jump(jump), .branch_taken(branch_taken),
    .offset(offset), .stall(stall), .imem_rdata(imem_rdata),
    .imem_busywait(imem_busywait), .imem_read(imem_read), .imem_addr(imem_addr),
    .pc(pc), .instruction(instruction), .instr_valid(instr_valid)
  );

  always #5 CLK = ~CLK;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [31:0] mem [256];
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_instr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (pc model %h)", tag, obs, expv, exp_pc);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Called at a falling edge with the DUT expected to be fetching exp_pc.
  task automatic do_instr(input int waits, input int stalls, input bit j, input bit b,
                          input logic [7:0] off);
    logic [7:0] idx;
    int woff;
    idx = exp_pc[9:2];
    for (int w = 0; w <= waits; w++) begin
      imem_busywait = (w < waits);
      imem_rdata    = (w < waits) ? $urandom : mem[idx];
      stall         = 1'($urandom);
      jump          = 1'($urandom);
      branch_taken  = 1'($urandom);
      offset        = 8'($urandom);
      chk("fetch_read", {31'b0, imem_read}, 32'd1);
      chk("fetch_valid", {31'b0, instr_valid}, 32'd0);
      chk("fetch_pc", pc, exp_pc);
      chk("fetch_addr", {24'b0, imem_addr}, {24'b0, idx});
      chk("fetch_instr_hold", instruction, exp_instr);
      next_cycle();
    end
    exp_instr = mem[idx];
    for (int s = 0; s <= stalls; s++) begin
      stall         = (s < stalls);
      imem_busywait = 1'($urandom);
      imem_rdata    = $urandom;
      jump          = (s < stalls) ? 1'($urandom) : j;
      branch_taken  = (s < stalls) ? 1'($urandom) : b;
      offset        = (s < stalls) ? 8'($urandom) : off;
      chk("valid_flag", {31'b0, instr_valid}, 32'd1);
      chk("valid_read", {31'b0, imem_read}, 32'd0);
      chk("valid_instr", instruction, exp_instr);
      chk("valid_pc", pc, exp_pc);
      next_cycle();
    end
    woff = int'($signed(off));
    exp_pc = exp_pc + 32'd4 + ((j || b) ? 32'(woff * 4) : 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, instruction, 32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd0);
    chk({tag, "_read"}, {31'b0, imem_read}, 32'd0);
    chk({tag, "_addr"}, {24'b0, imem_addr}, 32'd0);
  endtask

  // Release reset at a falling edge; the IDLE cycle is checked before the first edge.
  task automatic release_reset();
    RESET = 1'b1;
    exp_pc = '0;
    exp_instr = '0;
    #1;
    check_reset_outputs("idle");
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0001;

    // Reset held for three cycles with memory ready.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_reset_outputs("in_reset");
    end
    release_reset();

    do_instr(0, 0, 0, 0, 8'h00);   // pc 0
    do_instr(3, 0, 0, 0, 8'h00);   // pc 4, three wait states
    do_instr(0, 5, 0, 0, 8'h00);   // pc 8, five stall cycles
    do_instr(0, 0, 0, 0, 8'h00);   // pc 12
    do_instr(0, 0, 1, 0, 8'h02);   // pc 16 -> 28
    chk("jump_target", exp_pc, 32'd28);
    do_instr(0, 0, 0, 1, 8'hFD);   // pc 28 -> 20
    do_instr(1, 1, 1, 0, 8'hFF);   // pc 20 self-loop
    do_instr(0, 0, 1, 1, 8'h03);   // pc 20 -> 36, both redirects
    do_instr(0, 0, 0, 0, 8'h00);   // pc 36 -> 40

    // Reset in the middle of a waiting fetch at pc 40.
    imem_busywait = 1'b1;
    chk("prereset_pc", pc, 32'd40);
    chk("prereset_read", {31'b0, imem_read}, 32'd1);
    #2 RESET = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge CLK);
    check_reset_outputs("async_reset_hold");
    imem_busywait = 1'b0;
    release_reset();

    do_instr(0, 0, 0, 0, 8'h00);   // pc 0 after restart
    do_instr(0, 0, 1, 0, 8'hFD);   // pc 4 -> 0xFFFFFFFC
    chk("wrap_target", exp_pc, 32'hFFFF_FFFC);
    do_instr(2, 0, 0, 0, 8'h00);   // wrap to 0
    chk("wrap_zero", exp_pc, 32'h0);

    for (int n = 0; n < 60; n++)
      do_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               1'($urandom), 1'($urandom), 8'($urandom));
    do_instr(0, 0, 0, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
